decode_stage_pl: RTL and testbench

Parametrised decode stage for the 5-stage RISC-V pipeline. It owns the IF/ID pipeline register (valid bit, stall, flush), the integer register file with WB-to-ID write-through bypass, immediate generation for all base formats, and load-use hazard detection. It sits between fetch and the EX pipeline register. It drives stall/bubble requests back to fetch and forward to EX.

---
 rtl/decode_stage_pl.sv | 209 ++++++++++++++++++++
 tb/tb_decode_stage_pl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pl.sv
// -----------------------------------------------------------------------------
// decode_stage_pl
//
// Decode stage of the 5-stage RISC-V pipeline. Holds the IF/ID pipeline
// register, the integer register file (with WB-to-ID write-through bypass),
// immediate generation for every base format, and load-use hazard detection.
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   instr_f, pc_f, pc_plus4_f   fetched instruction and its PCs
//   valid_f                     instr_f is a real instruction
//   flush_d                     squash IF/ID (branch/jump resolved in EX)
//   mem_read_e, rd_e            EX-stage load flag and destination
//   reg_write_w, rd_w, result_w WB-stage register write port
//   stall_f                     hold PC/fetch this cycle
//   flush_e                     insert a bubble into ID/EX at the next edge
//   valid_d, pc_d, pc_plus4_d   IF/ID contents
//   opcode_d .. rd_d            decoded instruction fields
//   rd1_d, rd2_d                register operands (bypassed from WB)
//   imm_val_d                   sign-extended immediate
//
// Flow control: valid_f/valid_d mark real instructions; there is no ready
// signal. When stall_f is high fetch must present the same instruction again
// because IF/ID ignores instr_f that cycle. flush_d overrides the hold.
// -----------------------------------------------------------------------------
module decode_stage_pl #(
  parameter int          ADDRESS_WIDTH  = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          REG_ADDR_WIDTH = 5,
  parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               instr_f,
  input  logic [ADDRESS_WIDTH-1:0]  pc_f,
  input  logic [ADDRESS_WIDTH-1:0]  pc_plus4_f,
  input  logic                      valid_f,
  input  logic                      flush_d,
  input  logic                      mem_read_e,
  input  logic [REG_ADDR_WIDTH-1:0] rd_e,
  input  logic                      reg_write_w,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic [DATA_WIDTH-1:0]     result_w,
  output logic                      stall_f,
  output logic                      flush_e,
  output logic                      valid_d,
  output logic [ADDRESS_WIDTH-1:0]  pc_d,
  output logic [ADDRESS_WIDTH-1:0]  pc_plus4_d,
  output logic [6:0]                opcode_d,
  output logic [2:0]                funct3_d,
  output logic                      funct7b5_d,
  output logic [REG_ADDR_WIDTH-1:0] rs1_d,
  output logic [REG_ADDR_WIDTH-1:0] rs2_d,
  output logic [REG_ADDR_WIDTH-1:0] rd_d,
  output logic [DATA_WIDTH-1:0]     rd1_d,
  output logic [DATA_WIDTH-1:0]     rd2_d,
  output logic [DATA_WIDTH-1:0]     imm_val_d
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // IF/ID pipeline register
  logic [31:0]              instr_q;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_q;
  logic                     valid_q;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [6:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic [REG_ADDR_WIDTH-1:0] rd_raw;
  logic                      uses_rs1;
  logic                      uses_rs2;
  logic                      load_use;
  logic                      no_writeback;
  logic [31:0]               imm32;

  assign opcode = instr_q[6:0];
  assign rs1    = REG_ADDR_WIDTH'(instr_q[19:15]);
  assign rs2    = REG_ADDR_WIDTH'(instr_q[24:20]);
  assign rd_raw = REG_ADDR_WIDTH'(instr_q[11:7]);

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  // One bubble is enough: the bubble clears mem_read_e in EX next cycle.
  assign load_use = valid_q && mem_read_e && (rd_e != '0) &&
                    ((uses_rs1 && (rs1 == rd_e)) || (uses_rs2 && (rs2 == rd_e)));

  assign stall_f = load_use;
  assign flush_e = load_use;

  // ---------------------------------------------------------------------------
  // IF/ID register: flush beats the load-use hold
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (flush_d) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (!load_use) begin
      instr_q    <= instr_f;
      pc_q       <= pc_f;
      pc_plus4_q <= pc_plus4_f;
      valid_q    <= valid_f;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file (x0 is never written and always reads zero)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (reg_write_w && (rd_w != '0)) begin
      regs[rd_w] <= result_w;
    end
  end

  // WB writes in the same cycle are visible to decode immediately.
  always_comb begin
    rd1_d = regs[rs1];
    if (rs1 == '0)
      rd1_d = '0;
    else if (reg_write_w && (rd_w == rs1))
      rd1_d = result_w;
  end

  always_comb begin
    rd2_d = regs[rs2];
    if (rs2 == '0)
      rd2_d = '0;
    else if (reg_write_w && (rd_w == rs2))
      rd2_d = result_w;
  end

  // ---------------------------------------------------------------------------
  // Immediate generation (built at 32 bits, then sign-extended)
  // ---------------------------------------------------------------------------
  always_comb begin
    imm32 = '0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
        imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
      OP_STORE:
        imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      OP_BRANCH:
        imm32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                 instr_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {instr_q[31:12], 12'b0};
      OP_JAL:
        imm32 = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                 instr_q[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_val_d = DATA_WIDTH'($signed(imm32));

  // ---------------------------------------------------------------------------
  // Field outputs
  // ---------------------------------------------------------------------------
  // Bubbles, stores and branches must never write back.
  assign no_writeback = !valid_q || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  assign valid_d    = valid_q;
  assign pc_d       = pc_q;
  assign pc_plus4_d = pc_plus4_q;
  assign opcode_d   = opcode;
  assign funct3_d   = instr_q[14:12];
  assign funct7b5_d = instr_q[30];
  assign rs1_d      = rs1;
  assign rs2_d      = rs2;
  assign rd_d       = no_writeback ? '0 : rd_raw;

endmodule

// File: tb/tb_decode_stage_pl.sv
// -----------------------------------------------------------------------------
// tb_decode_stage_pl
//
// Directed bench for decode_stage_pl: a table of instructions with
// hand-computed decode results, plus short sequences for the WB bypass,
// load-use stall, flush priority and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_decode_stage_pl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk;
  logic          rst;
  logic [31:0]   instr_f;
  logic [AW-1:0] pc_f;
  logic [AW-1:0] pc_plus4_f;
  logic          valid_f;
  logic          flush_d;
  logic          mem_read_e;
  logic [RW-1:0] rd_e;
  logic          reg_write_w;
  logic [RW-1:0] rd_w;
  logic [DW-1:0] result_w;
  logic          stall_f;
  logic          flush_e;
  logic          valid_d;
  logic [AW-1:0] pc_d;
  logic [AW-1:0] pc_plus4_d;
  logic [6:0]    opcode_d;
  logic [2:0]    funct3_d;
  logic          funct7b5_d;
  logic [RW-1:0] rs1_d;
  logic [RW-1:0] rs2_d;
  logic [RW-1:0] rd_d;
  logic [DW-1:0] rd1_d;
  logic [DW-1:0] rd2_d;
  logic [DW-1:0] imm_val_d;

  int n_checks = 0;
  int n_errors = 0;

  decode_stage_pl dut (
    .clk        (clk),
    .rst        (rst),
    .instr_f    (instr_f),
    .pc_f       (pc_f),
    .pc_plus4_f (pc_plus4_f),
    .valid_f    (valid_f),
    .flush_d    (flush_d),
    .mem_read_e (mem_read_e),
    .rd_e       (rd_e),
    .reg_write_w(reg_write_w),
    .rd_w       (rd_w),
    .result_w   (result_w),
    .stall_f    (stall_f),
    .flush_e    (flush_e),
    .valid_d    (valid_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .opcode_d   (opcode_d),
    .funct3_d   (funct3_d),
    .funct7b5_d (funct7b5_d),
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .rd_d       (rd_d),
    .rd1_d      (rd1_d),
    .rd2_d      (rd2_d),
    .imm_val_d  (imm_val_d)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [AW-1:0] pc);
    instr_f    = instr;
    pc_f       = pc;
    pc_plus4_f = pc + 32'd4;
    valid_f    = 1'b1;
  endtask

  task automatic wb(input logic we, input logic [RW-1:0] rd, input logic [DW-1:0] data);
    reg_write_w = we;
    rd_w        = rd;
    result_w    = data;
  endtask

  // ---------------------------------------------------------------------------
  // Decode vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"addi_x1_5",   32'h00500093, 32'h00000005, 5'd1,  7'b0010011, 3'd0, 1'b0};
    vecs[1] = '{"addi_neg1",   32'hFFF00093, 32'hFFFFFFFF, 5'd1,  7'b0010011, 3'd0, 1'b1};
    vecs[2] = '{"sw_m4",       32'hFE742E23, 32'hFFFFFFFC, 5'd0,  7'b0100011, 3'd2, 1'b1};
    vecs[3] = '{"beq_m8",      32'hFE000CE3, 32'hFFFFFFF8, 5'd0,  7'b1100011, 3'd0, 1'b1};
    vecs[4] = '{"lui_abcde",   32'hABCDE4B7, 32'hABCDE000, 5'd9,  7'b0110111, 3'd6, 1'b0};
    vecs[5] = '{"jal_2048",    32'h001000EF, 32'h00000800, 5'd1,  7'b1101111, 3'd0, 1'b0};
    vecs[6] = '{"auipc_80000", 32'h80000297, 32'h80000000, 5'd5,  7'b0010111, 3'd0, 1'b0};
    vecs[7] = '{"add_r",       32'h002101B3, 32'h00000000, 5'd3,  7'b0110011, 3'd0, 1'b0};
    vecs[8] = '{"sub_r",       32'h403100B3, 32'h00000000, 5'd1,  7'b0110011, 3'd0, 1'b1};
    vecs[9] = '{"lw_8",        32'h00812503, 32'h00000008, 5'd10, 7'b0000011, 3'd2, 1'b0};
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    instr_f = 32'h0; pc_f = '0; pc_plus4_f = '0; valid_f = 1'b0;
    flush_d = 1'b0; mem_read_e = 1'b0; rd_e = '0;
    wb(1'b0, '0, '0);

    // Reset state
    repeat (2) tick();
    chk("rst_valid_d", 32'(valid_d), 32'd0);
    chk("rst_pc_d",    pc_d, 32'd0);
    chk("rst_pc4_d",   pc_plus4_d, 32'd0);
    chk("rst_opcode",  32'(opcode_d), 32'h13);
    chk("rst_rd_d",    32'(rd_d), 32'd0);
    chk("rst_stall",   32'(stall_f), 32'd0);
    chk("rst_flush_e", 32'(flush_e), 32'd0);
    chk("rst_imm",     imm_val_d, 32'd0);
    rst = 1'b0;

    // First instruction: addi x1,x0,5 appears one edge later
    fetch(32'h00500093, 32'h100);
    tick();
    chk("addi_valid", 32'(valid_d), 32'd1);
    chk("addi_rd",    32'(rd_d), 32'd1);
    chk("addi_rs1",   32'(rs1_d), 32'd0);
    chk("addi_rd1",   rd1_d, 32'd0);
    chk("addi_imm",   imm_val_d, 32'd5);
    chk("addi_pc",    pc_d, 32'h100);
    chk("addi_pc4",   pc_plus4_d, 32'h104);

    // Table-driven decode of every immediate format
    for (int i = 0; i < 10; i++) begin
      fetch(vecs[i].instr, 32'h400 + 32'(i * 4));
      tick();
      chk({vecs[i].name, "_imm"},    imm_val_d, vecs[i].imm);
      chk({vecs[i].name, "_rd"},     32'(rd_d), 32'(vecs[i].rd));
      chk({vecs[i].name, "_opcode"}, 32'(opcode_d), 32'(vecs[i].opcode));
      chk({vecs[i].name, "_funct3"}, 32'(funct3_d), 32'(vecs[i].funct3));
      chk({vecs[i].name, "_f7b5"},   32'(funct7b5_d), 32'(vecs[i].f7b5));
      chk({vecs[i].name, "_pc"},     pc_d, 32'h400 + 32'(i * 4));
    end

    // Invalid fetch: bubble forces rd_d to 0
    fetch(32'h00500093, 32'h500);
    valid_f = 1'b0;
    tick();
    chk("bubble_valid", 32'(valid_d), 32'd0);
    chk("bubble_rd",    32'(rd_d), 32'd0);

    // Register file write, then same-cycle WB bypass
    wb(1'b1, 5'd2, 32'h1234);
    fetch(32'h002101B3, 32'h600);           // add x3,x2,x2
    tick();
    wb(1'b0, '0, '0);
    valid_f = 1'b0;
    #1;
    chk("rf_rd1_x2", rd1_d, 32'h1234);
    chk("rf_rd2_x2", rd2_d, 32'h1234);
    // Hold IF/ID via a stall while WB overwrites x2
    mem_read_e = 1'b1; rd_e = 5'd2;
    wb(1'b1, 5'd2, 32'hBEEF);
    #1;
    chk("byp_rd1", rd1_d, 32'hBEEF);
    chk("byp_rd2", rd2_d, 32'hBEEF);
    tick();
    wb(1'b0, '0, '0);
    mem_read_e = 1'b0; rd_e = '0;
    #1;
    chk("byp_held_rd", 32'(rd_d), 32'd3);
    chk("rf_after_wb", rd1_d, 32'hBEEF);

    // Writes to x0 are discarded and never bypassed
    fetch(32'h00500093, 32'h700);           // addi x1,x0,5 reads x0
    tick();
    wb(1'b1, 5'd0, 32'hFFFF);
    #1;
    chk("x0_bypass", rd1_d, 32'd0);
    tick();
    wb(1'b0, '0, '0);
    #1;
    chk("x0_after", rd1_d, 32'd0);

    // Load-use hazard: add x4,x5,x6
    fetch(32'h00628233, 32'h800);
    tick();
    fetch(32'h00500093, 32'h804);
    mem_read_e = 1'b1; rd_e = 5'd6;
    #1;
    chk("lu_rs2_stall",   32'(stall_f), 32'd1);
    chk("lu_rs2_flush_e", 32'(flush_e), 32'd1);
    tick();
    chk("lu_hold_pc", pc_d, 32'h800);
    chk("lu_hold_rd", 32'(rd_d), 32'd4);
    rd_e = 5'd5;
    #1;
    chk("lu_rs1_stall", 32'(stall_f), 32'd1);
    rd_e = 5'd0;
    #1;
    chk("lu_rd0_nostall", 32'(stall_f), 32'd0);
    rd_e = 5'd4;
    #1;
    chk("lu_dest_nostall", 32'(stall_f), 32'd0);
    mem_read_e = 1'b0; rd_e = 5'd6;
    #1;
    chk("lu_nomem_nostall", 32'(flush_e), 32'd0);

    // Flush beats load-use
    mem_read_e = 1'b1; rd_e = 5'd6; flush_d = 1'b1;
    #1;
    chk("fl_stall_still", 32'(stall_f), 32'd1);
    tick();
    flush_d = 1'b0;
    #1;
    chk("fl_valid",  32'(valid_d), 32'd0);
    chk("fl_opcode", 32'(opcode_d), 32'h13);
    chk("fl_rd",     32'(rd_d), 32'd0);
    chk("fl_pc",     pc_d, 32'd0);
    chk("fl_stall",  32'(stall_f), 32'd0);
    mem_read_e = 1'b0; rd_e = '0;

    // Async reset in the middle of a stall
    wb(1'b1, 5'd7, 32'h55);
    fetch(32'h007380B3, 32'h900);           // add x1,x7,x7
    tick();
    wb(1'b0, '0, '0);
    mem_read_e = 1'b1; rd_e = 5'd7;
    #1;
    chk("ar_pre_rd1",   rd1_d, 32'h55);
    chk("ar_pre_stall", 32'(stall_f), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(valid_d), 32'd0);
    chk("ar_pc",    pc_d, 32'd0);
    chk("ar_stall", 32'(stall_f), 32'd0);
    mem_read_e = 1'b0; rd_e = '0;
    #1;
    rst = 1'b0;
    fetch(32'h007380B3, 32'hA00);
    tick();
    chk("ar_capture_pc", pc_d, 32'hA00);
    chk("ar_x7_rd1",     rd1_d, 32'd0);
    chk("ar_x7_rd2",     rd2_d, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
